// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event classifier: FSM state encoding,
// timer limit selection and default tick constants. The default ticks match
// the debouncer timer configuration at the system clock rate.
package btn_evt_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_GAP    = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HELD   = 3'd4
  } state_t;

  // Which terminal count the shared timer compares against.
  typedef enum logic [1:0] {
    LIM_LONG   = 2'd0,
    LIM_GAP    = 2'd1,
    LIM_REPEAT = 2'd2
  } lim_sel_t;

  localparam int DEF_LONG_TICKS   = 50_000_000;
  localparam int DEF_GAP_TICKS    = 15_000_000;
  localparam int DEF_REPEAT_TICKS = 10_000_000;
  localparam int DEF_CNT_W        = 26;

endpackage

// File: rtl/button_event_classifier_if.sv
// Signal bundle between the debouncer side and the classifier.
// Protocol: debounced is a clean level (1 = pressed), sampled every clock.
// single_click, double_click, long_press and repeat_pulse are registered
// one-cycle pulses with no backpressure; at most one is high per cycle.
// busy is a level, high while a press sequence is in progress.
// dbg_state mirrors the classifier FSM state for observation only.
interface button_event_classifier_if;
  import btn_evt_pkg::*;

  logic   debounced;
  logic   single_click;
  logic   double_click;
  logic   long_press;
  logic   repeat_pulse;
  logic   busy;
  state_t dbg_state;

  modport master (
    output debounced,
    input  single_click, double_click, long_press, repeat_pulse, busy, dbg_state
  );

  modport slave (
    input  debounced,
    output single_click, double_click, long_press, repeat_pulse, busy, dbg_state
  );
endinterface

// File: rtl/btn_evt_timer.sv
// Clearable up-counter shared by the PRESS1, GAP and HELD phases. tc_o is
// high when the count equals the selected limit minus one, so the FSM acts
// on the edge that completes the requested number of ticks.
module btn_evt_timer
  import btn_evt_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clr_i,
  input  logic     en_i,
  input  lim_sel_t sel_i,
  output logic     tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] limit;

  // Terminal value for the phase the FSM is currently timing.
  always_comb begin
    limit = CNT_W'(LONG_TICKS - 1);
    case (sel_i)
      LIM_LONG:   limit = CNT_W'(LONG_TICKS - 1);
      LIM_GAP:    limit = CNT_W'(GAP_TICKS - 1);
      LIM_REPEAT: limit = CNT_W'(REPEAT_TICKS - 1);
      default:    limit = CNT_W'(LONG_TICKS - 1);
    endcase
  end

  // Clear wins over enable; otherwise the count holds.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == limit);

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced button activity into single click, double click and
// long press pulses. Optional auto-repeat while held is enabled by defining
// BTN_AUTOREPEAT_EN; without it repeat_pulse is constant 0.
module button_event_classifier
  import btn_evt_pkg::*;
#(
  parameter int LONG_TICKS   = DEF_LONG_TICKS,
  parameter int GAP_TICKS    = DEF_GAP_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                      clk,
  input logic                      reset,
  button_event_classifier_if.slave bus
);

  state_t   state_q, state_d;
  logic     d_q;
  logic     rise, fall;
  logic     single_q, single_d;
  logic     double_q, double_d;
  logic     long_q, long_d;
  logic     busy_q;
  logic     tmr_clr, tmr_en, tmr_tc;
  lim_sel_t tmr_sel;
`ifdef BTN_AUTOREPEAT_EN
  logic     repeat_q, repeat_d;
`endif

  // d_q resets high so a button held through reset needs a fresh press.
  assign rise = bus.debounced & ~d_q;
  assign fall = ~bus.debounced & d_q;

  btn_evt_timer #(
    .CNT_W        (CNT_W),
    .LONG_TICKS   (LONG_TICKS),
    .GAP_TICKS    (GAP_TICKS),
    .REPEAT_TICKS (REPEAT_TICKS)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .sel_i (tmr_sel),
    .tc_o  (tmr_tc)
  );

  // Next state, event pulses and timer control. Edges take priority over
  // timeouts, so a release or second press always wins over the tick limit.
  always_comb begin
    state_d  = state_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_d = 1'b0;
`endif
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    tmr_sel  = LIM_LONG;
    case (state_q)
      ST_IDLE: begin
        tmr_clr = 1'b1;
        if (rise) state_d = ST_PRESS1;
      end
      ST_PRESS1: begin
        tmr_sel = LIM_LONG;
        if (fall) begin
          state_d = ST_GAP;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
          tmr_clr = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_GAP: begin
        tmr_sel = LIM_GAP;
        if (rise) begin
          state_d = ST_PRESS2;
        end else if (tmr_tc) begin
          state_d  = ST_IDLE;
          single_d = 1'b1;
          tmr_clr  = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_PRESS2: begin
        // Count is held; second press length does not matter.
        if (fall) begin
          state_d  = ST_IDLE;
          double_d = 1'b1;
        end
      end
      ST_HELD: begin
        tmr_sel = LIM_REPEAT;
        if (fall) begin
          state_d = ST_IDLE;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (tmr_tc) begin
          repeat_d = 1'b1;
          tmr_clr  = 1'b1;
        end else begin
          tmr_en = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      d_q      <= 1'b1;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      d_q      <= bus.debounced;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= (state_d != ST_IDLE);
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= repeat_d;
`endif
    end
  end

  assign bus.single_click = single_q;
  assign bus.double_click = double_q;
  assign bus.long_press   = long_q;
  assign bus.busy         = busy_q;
  assign bus.dbg_state    = state_q;
`ifdef BTN_AUTOREPEAT_EN
  assign bus.repeat_pulse = repeat_q;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_classifier.sv
// Bench for button_event_classifier with LONG=8, GAP=6, REPEAT=4 ticks.
// Expected events ({kind, cycle}) are queued when a press pattern is driven
// and popped by a monitor whenever the DUT emits a pulse.
module tb_button_event_classifier;
  import btn_evt_pkg::*;

  localparam int LONG_T = 8;
  localparam int GAP_T  = 6;
  localparam int REP_T  = 4;
  localparam int K_SINGLE = 1, K_DOUBLE = 2, K_LONG = 3, K_REPEAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [19:0] exp_q[$];

  button_event_classifier_if bus();

  button_event_classifier #(
    .LONG_TICKS   (LONG_T),
    .GAP_TICKS    (GAP_T),
    .REPEAT_TICKS (REP_T),
    .CNT_W        (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and edge counter: cyc equals the index of the latest rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int h1;    // first press length (cycles)
    int l1;    // gap before second press (used when h2 > 0)
    int h2;    // second press length, 0 = no second press
    int kind;  // expected event kind
    int off;   // expected event edge, relative to pattern start
  } vec_t;

  vec_t vecs[9];

  // Drive debounced for n cycles, returning #1 after the last edge.
  task automatic hold(input logic v, input int n);
    bus.debounced = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_reset(input logic v, input int n);
    reset = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_evt(input int kind, input int at);
    exp_q.push_back({4'(kind), 16'(at)});
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_busy"}, int'(bus.busy), 0);
  endtask

  // Monitor: every pulse must match the head of the expected queue.
  logic [3:0] pulses;
  int         act_kind;
  logic [19:0] exp_e;
  always @(negedge clk) begin
    pulses = {bus.repeat_pulse, bus.long_press, bus.double_click, bus.single_click};
    if (!reset && pulses != 4'b0) begin
      check("one_hot_pulses", $countones(pulses), 1);
      act_kind = pulses[0] ? K_SINGLE : pulses[1] ? K_DOUBLE : pulses[2] ? K_LONG : K_REPEAT;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d @%0d, expected none", act_kind, cyc);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e != {4'(act_kind), 16'(cyc)}) begin
          n_fail++;
          $display("FAIL event: got kind %0d @%0d, expected kind %0d @%0d",
                   act_kind, cyc, int'(exp_e[19:16]), int'(exp_e[15:0]));
        end
      end
    end
  end

  initial begin
    int c;
    // h1, l1, h2, kind, offset from start (first rise edge is start+1)
    vecs[0] = '{3, 0, 0,  K_SINGLE, 10};  // single: fall+6
    vecs[1] = '{1, 0, 0,  K_SINGLE,  8};
    vecs[2] = '{7, 0, 0,  K_SINGLE, 14};  // just short of long press
    vecs[3] = '{8, 0, 0,  K_SINGLE, 15};  // fall beats terminal count
    vecs[4] = '{9, 0, 0,  K_LONG,    9};  // shortest long press
    vecs[5] = '{3, 2, 3,  K_DOUBLE,  9};
    vecs[6] = '{3, 6, 2,  K_DOUBLE, 12};  // rise coincides with gap timeout
    vecs[7] = '{2, 1, 12, K_DOUBLE, 16};  // long second press stays double
    vecs[8] = '{3, 1, 1,  K_DOUBLE,  6};

    // Reset state with the button released.
    bus.debounced = 1'b0;
    set_reset(1'b1, 3);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_state", int'(bus.dbg_state), int'(ST_IDLE));
    check("rst_single", int'(bus.single_click), 0);
    check("rst_double", int'(bus.double_click), 0);
    check("rst_long", int'(bus.long_press), 0);
    check("rst_repeat", int'(bus.repeat_pulse), 0);

    // Button held through reset release must be ignored.
    bus.debounced = 1'b1;
    set_reset(1'b1, 2);
    set_reset(1'b0, 12);
    check("held_thru_reset_busy", int'(bus.busy), 0);
    hold(1'b0, 4);
    check_idle("held_thru_reset");

    // Table-driven patterns.
    for (int i = 0; i < 9; i++) begin
      c = cyc;
      expect_evt(vecs[i].kind, c + vecs[i].off);
      hold(1'b1, vecs[i].h1);
      if (vecs[i].h2 > 0) begin
        hold(1'b0, vecs[i].l1);
        hold(1'b1, vecs[i].h2);
      end
      hold(1'b0, 12);
      check_idle($sformatf("vec%0d", i));
    end

    // Long hold of 20 cycles; optional repeats at +4 and +8 after long_press.
    c = cyc;
    expect_evt(K_LONG, c + LONG_T + 1);
`ifdef BTN_AUTOREPEAT_EN
    expect_evt(K_REPEAT, c + LONG_T + 1 + REP_T);
    expect_evt(K_REPEAT, c + LONG_T + 1 + 2 * REP_T);
`endif
    hold(1'b1, 12);
    check("long_held_state", int'(bus.dbg_state), int'(ST_HELD));
    check("long_held_busy", int'(bus.busy), 1);
    hold(1'b1, 8);
    hold(1'b0, 12);
    check_idle("long_hold");

    // Reset in GAP with the button pressed across reset release.
    hold(1'b1, 3);
    hold(1'b0, 2);
    check("gap_state", int'(bus.dbg_state), int'(ST_GAP));
    bus.debounced = 1'b1;
    set_reset(1'b1, 2);
    check("gap_reset_busy", int'(bus.busy), 0);
    set_reset(1'b0, 10);
    check("gap_reset_after_busy", int'(bus.busy), 0);
    hold(1'b0, 12);
    check_idle("gap_reset");

    // Fresh press after the aborted sequence classifies normally.
    c = cyc;
    expect_evt(K_SINGLE, c + 10);
    hold(1'b1, 3);
    hold(1'b0, 12);
    check_idle("post_reset_single");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
